// File: rtl/sram_arbiter_if.sv
// ---------------------------------------------------------------------------
// sram_arbiter_if
// Bundles every request/response and SRAM-side signal of the two-port SRAM
// arbiter so the arbiter and its environment connect through one port.
//
// Signals:
//   req_a/req_b        requests from port A (control unit) / B (scanner)
//   op_a/op_b          00 read, 01 load, 10 clear, 11 clear-all
//   addr_a/addr_b      target location (ignored for clear-all)
//   wdata_a/wdata_b    load data
//   gnt_a/gnt_b        one-cycle grant pulse
//   done_a/done_b      one-cycle completion pulse
//   rdata              last read result, shared by both ports
//   busy               high whenever the arbiter is not idle
//   sram_RD/Load/Clear strobes to the SRAM latch bank
//   sram_Address       address to the SRAM
//   sram_dataIn        write data to the SRAM
//   sram_dataOut       read data from the SRAM
//
// Modports:
//   slave  - the arbiter's view
//   master - the requesters' and SRAM's view (used by the environment)
// ---------------------------------------------------------------------------
interface sram_arbiter_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 3
);
    logic              req_a;
    logic              req_b;
    logic [1:0]        op_a;
    logic [1:0]        op_b;
    logic [ADDR_W-1:0] addr_a;
    logic [ADDR_W-1:0] addr_b;
    logic [DATA_W-1:0] wdata_a;
    logic [DATA_W-1:0] wdata_b;
    logic              gnt_a;
    logic              gnt_b;
    logic              done_a;
    logic              done_b;
    logic [DATA_W-1:0] rdata;
    logic              busy;
    logic              sram_RD;
    logic              sram_Load;
    logic              sram_Clear;
    logic [ADDR_W-1:0] sram_Address;
    logic [DATA_W-1:0] sram_dataIn;
    logic [DATA_W-1:0] sram_dataOut;

    modport slave (
        input  req_a, req_b, op_a, op_b, addr_a, addr_b, wdata_a, wdata_b,
        input  sram_dataOut,
        output gnt_a, gnt_b, done_a, done_b, rdata, busy,
        output sram_RD, sram_Load, sram_Clear, sram_Address, sram_dataIn
    );

    modport master (
        output req_a, req_b, op_a, op_b, addr_a, addr_b, wdata_a, wdata_b,
        output sram_dataOut,
        input  gnt_a, gnt_b, done_a, done_b, rdata, busy,
        input  sram_RD, sram_Load, sram_Clear, sram_Address, sram_dataIn
    );
endinterface

// File: rtl/sram_arbiter.sv
// ---------------------------------------------------------------------------
// sram_arbiter
// Round-robin arbiter and strobe sequencer for the 8 x 32-bit SRAM latch
// bank. Two masters issue read, load, clear and clear-all requests; the
// winner's operation is replayed onto the SRAM strobes for exactly the
// cycles it needs, and completion is signalled with a one-cycle done pulse.
//
// Ports:
//   clk     single clock, rising edge
//   rst     asynchronous active-high reset
//   bus_io  sram_arbiter_if.slave: request/grant/done handshakes for ports
//           A and B, shared rdata, busy, and the SRAM strobe/address/data
//           signals
//
// Every output comes straight from a flop; the next-state logic computes
// the next value of each output alongside the next FSM state.
// ---------------------------------------------------------------------------
module sram_arbiter #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 3,
    parameter int DEPTH  = 8
) (
    input  logic           clk,
    input  logic           rst,
    sram_arbiter_if.slave  bus_io
);

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        WAIT,
        SWEEP,
        DONE
    } state_t;

    localparam logic [1:0] OP_READ   = 2'b00;
    localparam logic [1:0] OP_LOAD   = 2'b01;
    localparam logic [1:0] OP_CLEAR  = 2'b10;
    localparam logic [1:0] OP_CLRALL = 2'b11;

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

    state_t            state_q,       state_d;
    logic              prio_q,        prio_d;
    logic              grantPort_q,   grantPort_d;
    logic [1:0]        opHeld_q,      opHeld_d;
    logic [ADDR_W-1:0] addrHeld_q,    addrHeld_d;
    logic [DATA_W-1:0] wdataHeld_q,   wdataHeld_d;
    logic [ADDR_W-1:0] sweepCnt_q,    sweepCnt_d;

    logic              gntA_q,        gntA_d;
    logic              gntB_q,        gntB_d;
    logic              doneA_q,       doneA_d;
    logic              doneB_q,       doneB_d;
    logic [DATA_W-1:0] rdata_q,       rdata_d;
    logic              busy_q,        busy_d;
    logic              sramRd_q,      sramRd_d;
    logic              sramLoad_q,    sramLoad_d;
    logic              sramClear_q,   sramClear_d;
    logic [ADDR_W-1:0] sramAddr_q,    sramAddr_d;
    logic [DATA_W-1:0] sramDin_q,     sramDin_d;

    logic              pickB;

    // State register and output flops. Reset abandons any in-flight
    // operation: nothing survives, so no done pulse can follow it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            prio_q      <= 1'b0;
            grantPort_q <= 1'b0;
            opHeld_q    <= OP_READ;
            addrHeld_q  <= '0;
            wdataHeld_q <= '0;
            sweepCnt_q  <= '0;
            gntA_q      <= 1'b0;
            gntB_q      <= 1'b0;
            doneA_q     <= 1'b0;
            doneB_q     <= 1'b0;
            rdata_q     <= '0;
            busy_q      <= 1'b0;
            sramRd_q    <= 1'b0;
            sramLoad_q  <= 1'b0;
            sramClear_q <= 1'b0;
            sramAddr_q  <= '0;
            sramDin_q   <= '0;
        end else begin
            state_q     <= state_d;
            prio_q      <= prio_d;
            grantPort_q <= grantPort_d;
            opHeld_q    <= opHeld_d;
            addrHeld_q  <= addrHeld_d;
            wdataHeld_q <= wdataHeld_d;
            sweepCnt_q  <= sweepCnt_d;
            gntA_q      <= gntA_d;
            gntB_q      <= gntB_d;
            doneA_q     <= doneA_d;
            doneB_q     <= doneB_d;
            rdata_q     <= rdata_d;
            busy_q      <= busy_d;
            sramRd_q    <= sramRd_d;
            sramLoad_q  <= sramLoad_d;
            sramClear_q <= sramClear_d;
            sramAddr_q  <= sramAddr_d;
            sramDin_q   <= sramDin_d;
        end
    end

    // Next-state logic. grantPort/prio use 0 for port A and 1 for port B;
    // prio names the port that wins a tie and always flips to the port that
    // did not just win.
    always_comb begin
        state_d     = state_q;
        prio_d      = prio_q;
        grantPort_d = grantPort_q;
        opHeld_d    = opHeld_q;
        addrHeld_d  = addrHeld_q;
        wdataHeld_d = wdataHeld_q;
        sweepCnt_d  = sweepCnt_q;
        rdata_d     = rdata_q;
        pickB       = 1'b0;

        case (state_q)
            IDLE: begin
                if (bus_io.req_a || bus_io.req_b) begin
                    pickB       = bus_io.req_b && (!bus_io.req_a || prio_q);
                    grantPort_d = pickB;
                    prio_d      = !pickB;
                    opHeld_d    = pickB ? bus_io.op_b    : bus_io.op_a;
                    addrHeld_d  = pickB ? bus_io.addr_b  : bus_io.addr_a;
                    wdataHeld_d = pickB ? bus_io.wdata_b : bus_io.wdata_a;
                    sweepCnt_d  = '0;
                    state_d     = (opHeld_d == OP_CLRALL) ? SWEEP : ISSUE;
                end
            end
            ISSUE: begin
                state_d = (opHeld_q == OP_READ) ? WAIT : DONE;
            end
            WAIT: begin
                // The SRAM presents the read word during this cycle.
                rdata_d = bus_io.sram_dataOut;
                state_d = DONE;
            end
            SWEEP: begin
                // Counter wraps back to 0 on the last address since
                // DEPTH is exactly 2^ADDR_W.
                sweepCnt_d = sweepCnt_q + ADDR_W'(1);
                if (sweepCnt_q == LAST_ADDR) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Output next-values are derived from the state being entered so that
    // the registered outputs line up with that state.
    always_comb begin
        gntA_d      = 1'b0;
        gntB_d      = 1'b0;
        doneA_d     = 1'b0;
        doneB_d     = 1'b0;
        busy_d      = (state_d != IDLE);
        sramRd_d    = 1'b0;
        sramLoad_d  = 1'b0;
        sramClear_d = 1'b0;
        sramAddr_d  = '0;
        sramDin_d   = '0;

        if ((state_q == IDLE) && (state_d != IDLE)) begin
            gntA_d = !grantPort_d;
            gntB_d = grantPort_d;
        end

        if (state_d == DONE) begin
            doneA_d = !grantPort_d;
            doneB_d = grantPort_d;
        end

        if (state_d == ISSUE) begin
            sramRd_d    = (opHeld_d == OP_READ);
            sramLoad_d  = (opHeld_d == OP_LOAD);
            sramClear_d = (opHeld_d == OP_CLEAR);
            sramAddr_d  = addrHeld_d;
            if (opHeld_d == OP_LOAD) begin
                sramDin_d = wdataHeld_d;
            end
        end else if (state_d == SWEEP) begin
            sramClear_d = 1'b1;
            sramAddr_d  = sweepCnt_d;
        end
    end

    assign bus_io.gnt_a        = gntA_q;
    assign bus_io.gnt_b        = gntB_q;
    assign bus_io.done_a       = doneA_q;
    assign bus_io.done_b       = doneB_q;
    assign bus_io.rdata        = rdata_q;
    assign bus_io.busy         = busy_q;
    assign bus_io.sram_RD      = sramRd_q;
    assign bus_io.sram_Load    = sramLoad_q;
    assign bus_io.sram_Clear   = sramClear_q;
    assign bus_io.sram_Address = sramAddr_q;
    assign bus_io.sram_dataIn  = sramDin_q;

endmodule

// File: tb/tb_sram_arbiter.sv
// ---------------------------------------------------------------------------
// tb_sram_arbiter
// Drives both requester ports of sram_arbiter, models the SRAM latch bank
// behind it, and checks grants, done pulses, strobe sequences and read data
// against a transaction-level reference model (memory array + last-winner
// priority + per-operation latency table).
// ---------------------------------------------------------------------------
module tb_sram_arbiter;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 3;
    localparam int DEPTH  = 8;

    localparam logic [1:0] OP_READ   = 2'b00;
    localparam logic [1:0] OP_LOAD   = 2'b01;
    localparam logic [1:0] OP_CLEAR  = 2'b10;
    localparam logic [1:0] OP_CLRALL = 2'b11;

    // kind codes used in strobe logs
    localparam int K_RD = 0;
    localparam int K_LD = 1;
    localparam int K_CL = 2;

    typedef struct packed {
        int          cyc;
        int          kind;
        logic [2:0]  addr;
        logic [31:0] din;
    } strobe_t;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    sram_arbiter_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

    sram_arbiter #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
        .clk    (clk),
        .rst    (rst),
        .bus_io (bus)
    );

    // SRAM latch bank model: strobes act on the rising edge that ends
    // their cycle; a read word is presented in the following cycle.
    logic [31:0] sramMem [DEPTH];
    logic [31:0] sramOut;

    always @(posedge clk) begin
        if (bus.sram_Load)  sramMem[bus.sram_Address] <= bus.sram_dataIn;
        if (bus.sram_Clear) sramMem[bus.sram_Address] <= '0;
        if (bus.sram_RD)    sramOut <= sramMem[bus.sram_Address];
    end

    assign bus.sram_dataOut = sramOut;

    int nCompared = 0;
    int nMismatch = 0;

    // reference model state
    logic [31:0] expMem [DEPTH];
    logic [31:0] expRdata;
    bit          lastGntB;
    int          expOrder[$];
    strobe_t     expLog[$];
    int          expGntCyc [2];
    int          expDoneCyc [2];
    logic [31:0] expRdataDone [2];
    int          expBusy;

    // observations of one transaction window
    int          obsOrder[$];
    strobe_t     obsLog[$];
    int          obsGntCyc [2];
    int          obsDoneCyc [2];
    int          obsGntCnt [2];
    int          obsDoneCnt [2];
    logic [31:0] obsRdata [2];
    int          obsIllegal;
    int          obsBusy;
    bit          obsTimeout;

    // Latency from cycle 0 to the done cycle for each operation.
    function automatic int doneLatency(input logic [1:0] op);
        case (op)
            OP_READ:   return 3;
            OP_CLRALL: return 9;
            default:   return 2;
        endcase
    endfunction

    // Reference model: predicts grant order, timing, strobe log and read
    // data for one or two simultaneous requests, and updates memory.
    task automatic predict(input bit enA, input bit enB,
                           input logic [1:0] opA, input logic [1:0] opB,
                           input logic [2:0] adA, input logic [2:0] adB,
                           input logic [31:0] wdA, input logic [31:0] wdB);
        int t, first, p, dur;
        logic [1:0] op;
        logic [2:0] ad;
        logic [31:0] wd;
        strobe_t e;
        expOrder.delete();
        expLog.delete();
        expBusy = 0;
        if (enA && enB) first = lastGntB ? 0 : 1;
        else            first = enA ? 0 : 1;
        t = 1;
        for (int k = 0; k < 2; k++) begin
            p = (k == 0) ? first : 1 - first;
            if ((p == 0 && enA) || (p == 1 && enB)) begin
                op = p ? opB : opA;
                ad = p ? adB : adA;
                wd = p ? wdB : wdA;
                expOrder.push_back(p);
                expGntCyc[p] = t;
                lastGntB = (p == 1);
                dur = doneLatency(op);
                e.cyc = t; e.addr = ad; e.din = '0;
                case (op)
                    OP_READ: begin
                        e.kind = K_RD; expLog.push_back(e);
                        expRdata = expMem[ad];
                    end
                    OP_LOAD: begin
                        e.kind = K_LD; e.din = wd; expLog.push_back(e);
                        expMem[ad] = wd;
                    end
                    OP_CLEAR: begin
                        e.kind = K_CL; expLog.push_back(e);
                        expMem[ad] = '0;
                    end
                    default: begin
                        for (int i = 0; i < DEPTH; i++) begin
                            e.cyc = t + i; e.kind = K_CL; e.addr = 3'(i);
                            expLog.push_back(e);
                            expMem[i] = '0;
                        end
                    end
                endcase
                expDoneCyc[p]   = t + dur - 1;
                expRdataDone[p] = expRdata;
                expBusy         = expBusy + dur;
                t               = t + dur + 1;
            end
        end
    endtask

    // Raises the requested ports in the same cycle, releases each on its
    // grant and records everything the DUT does until it is idle again.
    task automatic do_pair(input bit enA, input bit enB,
                           input logic [1:0] opA, input logic [1:0] opB,
                           input logic [2:0] adA, input logic [2:0] adB,
                           input logic [31:0] wdA, input logic [31:0] wdB);
        int c, nStr;
        bit fin;
        strobe_t e;
        obsOrder.delete();
        obsLog.delete();
        for (int p = 0; p < 2; p++) begin
            obsGntCyc[p] = -1; obsDoneCyc[p] = -1;
            obsGntCnt[p] = 0;  obsDoneCnt[p] = 0; obsRdata[p] = '0;
        end
        obsIllegal = 0;
        obsBusy    = 0;
        @(negedge clk);
        bus.req_a = enA; bus.op_a = opA; bus.addr_a = adA; bus.wdata_a = wdA;
        bus.req_b = enB; bus.op_b = opB; bus.addr_b = adB; bus.wdata_b = wdB;
        c = 0;
        fin = 0;
        while (!fin && c < 60) begin
            @(negedge clk);
            c++;
            if (bus.gnt_a) begin
                obsOrder.push_back(0); obsGntCyc[0] = c; obsGntCnt[0]++;
                bus.req_a = 1'b0;
            end
            if (bus.gnt_b) begin
                obsOrder.push_back(1); obsGntCyc[1] = c; obsGntCnt[1]++;
                bus.req_b = 1'b0;
            end
            if (bus.done_a) begin
                obsDoneCyc[0] = c; obsDoneCnt[0]++; obsRdata[0] = bus.rdata;
            end
            if (bus.done_b) begin
                obsDoneCyc[1] = c; obsDoneCnt[1]++; obsRdata[1] = bus.rdata;
            end
            nStr = int'(bus.sram_RD) + int'(bus.sram_Load) + int'(bus.sram_Clear);
            if (nStr > 1) obsIllegal++;
            if (nStr == 0 && (bus.sram_Address != 0 || bus.sram_dataIn != 0)) obsIllegal++;
            e.cyc = c; e.addr = bus.sram_Address; e.din = '0;
            if (bus.sram_RD)    begin e.kind = K_RD; obsLog.push_back(e); end
            if (bus.sram_Load)  begin e.kind = K_LD; e.din = bus.sram_dataIn; obsLog.push_back(e); end
            if (bus.sram_Clear) begin e.kind = K_CL; e.din = '0; obsLog.push_back(e); end
            if (bus.busy) obsBusy++;
            if ((!enA || obsDoneCnt[0] > 0) && (!enB || obsDoneCnt[1] > 0) && !bus.busy) fin = 1;
        end
        obsTimeout = !fin;
        bus.req_a = 1'b0;
        bus.req_b = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        nCompared++;
        if ({bus.gnt_a, bus.gnt_b, bus.done_a, bus.done_b, bus.busy} !== 5'b0) begin
            nMismatch++;
            $display("[TB] FAIL reset_handshake: got %b expected 00000",
                     {bus.gnt_a, bus.gnt_b, bus.done_a, bus.done_b, bus.busy});
        end
        nCompared++;
        if ({bus.sram_RD, bus.sram_Load, bus.sram_Clear} !== 3'b0) begin
            nMismatch++;
            $display("[TB] FAIL reset_strobes: got %b expected 000",
                     {bus.sram_RD, bus.sram_Load, bus.sram_Clear});
        end
        nCompared++;
        if (bus.rdata !== 32'h0 || bus.sram_Address !== 3'h0 || bus.sram_dataIn !== 32'h0) begin
            nMismatch++;
            $display("[TB] FAIL reset_data: got rdata=%h addr=%0d din=%h expected all 0",
                     bus.rdata, bus.sram_Address, bus.sram_dataIn);
        end
        rst = 1'b0;
        expRdata = '0;
        lastGntB = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_load_fill();
        for (int i = 0; i < DEPTH; i++) begin
            predict(1, 0, OP_LOAD, OP_READ, 3'(i), 3'd0, 32'(2 * i), 32'd0);
            do_pair(1, 0, OP_LOAD, OP_READ, 3'(i), 3'd0, 32'(2 * i), 32'd0);
            nCompared++;
            if (obsTimeout !== 1'b0) begin nMismatch++; $display("[TB] FAIL load_timeout i=%0d: no done_a within budget", i); end
            nCompared++;
            if (obsGntCyc[0] !== 1 || obsDoneCyc[0] !== 2) begin
                nMismatch++;
                $display("[TB] FAIL load_timing i=%0d: got gnt@%0d done@%0d expected gnt@1 done@2", i, obsGntCyc[0], obsDoneCyc[0]);
            end
            nCompared++;
            if (obsLog.size() !== 1) begin
                nMismatch++;
                $display("[TB] FAIL load_strobe_count i=%0d: got %0d expected 1", i, obsLog.size());
            end else begin
                nCompared++;
                if (obsLog[0] !== expLog[0]) begin
                    nMismatch++;
                    $display("[TB] FAIL load_strobe i=%0d: got cyc%0d kind%0d a%0d d%h expected cyc%0d kind%0d a%0d d%h", i,
                             obsLog[0].cyc, obsLog[0].kind, obsLog[0].addr, obsLog[0].din,
                             expLog[0].cyc, expLog[0].kind, expLog[0].addr, expLog[0].din);
                end
            end
            nCompared++;
            if (obsIllegal !== 0) begin nMismatch++; $display("[TB] FAIL load_illegal i=%0d: got %0d expected 0", i, obsIllegal); end
        end
    endtask

    task automatic test_read_all();
        for (int i = 0; i < DEPTH; i++) begin
            predict(0, 1, OP_READ, OP_READ, 3'd0, 3'(i), 32'd0, 32'd0);
            do_pair(0, 1, OP_READ, OP_READ, 3'd0, 3'(i), 32'd0, 32'd0);
            nCompared++;
            if (obsTimeout !== 1'b0) begin nMismatch++; $display("[TB] FAIL read_timeout i=%0d: no done_b within budget", i); end
            nCompared++;
            if (obsGntCyc[1] !== 1 || obsDoneCyc[1] !== 3) begin
                nMismatch++;
                $display("[TB] FAIL read_timing i=%0d: got gnt@%0d done@%0d expected gnt@1 done@3", i, obsGntCyc[1], obsDoneCyc[1]);
            end
            nCompared++;
            if (obsRdata[1] !== 32'(2 * i)) begin
                nMismatch++;
                $display("[TB] FAIL read_data i=%0d: got %h expected %h", i, obsRdata[1], 32'(2 * i));
            end
            nCompared++;
            if (obsLog.size() !== 1 || obsLog[0] !== expLog[0]) begin
                nMismatch++;
                $display("[TB] FAIL read_strobes i=%0d: got %0d strobes expected one RD at addr %0d", i, obsLog.size(), i);
            end
        end
    endtask

    task automatic test_round_robin();
        logic [31:0] wa, wb;
        for (int r = 0; r < 4; r++) begin
            wa = $urandom; wb = $urandom;
            predict(1, 1, OP_LOAD, OP_LOAD, 3'($urandom_range(0, 7)), 3'(r), wa, wb);
            do_pair(1, 1, OP_LOAD, OP_LOAD, expLog[0].addr, 3'(r), wa, wb);
            nCompared++;
            if (obsTimeout !== 1'b0) begin nMismatch++; $display("[TB] FAIL rr_timeout round=%0d: both ports not served", r); end
            nCompared++;
            if (obsOrder.size() !== 2) begin
                nMismatch++;
                $display("[TB] FAIL rr_grants round=%0d: got %0d grants expected 2", r, obsOrder.size());
            end else begin
                nCompared++;
                if (obsOrder[0] !== expOrder[0] || obsOrder[1] !== expOrder[1]) begin
                    nMismatch++;
                    $display("[TB] FAIL rr_order round=%0d: got %0d,%0d expected %0d,%0d", r,
                             obsOrder[0], obsOrder[1], expOrder[0], expOrder[1]);
                end
            end
            nCompared++;
            if (obsDoneCyc[0] !== expDoneCyc[0] || obsDoneCyc[1] !== expDoneCyc[1]) begin
                nMismatch++;
                $display("[TB] FAIL rr_done round=%0d: got A@%0d B@%0d expected A@%0d B@%0d", r,
                         obsDoneCyc[0], obsDoneCyc[1], expDoneCyc[0], expDoneCyc[1]);
            end
        end
    endtask

    task automatic test_clear_all();
        predict(1, 0, OP_CLRALL, OP_READ, 3'd5, 3'd0, 32'd0, 32'd0);
        do_pair(1, 0, OP_CLRALL, OP_READ, 3'd5, 3'd0, 32'd0, 32'd0);
        nCompared++;
        if (obsTimeout !== 1'b0) begin nMismatch++; $display("[TB] FAIL clrall_timeout: no done_a within budget"); end
        nCompared++;
        if (obsGntCyc[0] !== 1 || obsDoneCyc[0] !== 9) begin
            nMismatch++;
            $display("[TB] FAIL clrall_timing: got gnt@%0d done@%0d expected gnt@1 done@9", obsGntCyc[0], obsDoneCyc[0]);
        end
        nCompared++;
        if (obsLog.size() !== DEPTH) begin
            nMismatch++;
            $display("[TB] FAIL clrall_strobe_count: got %0d expected %0d", obsLog.size(), DEPTH);
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                nCompared++;
                if (obsLog[i] !== expLog[i]) begin
                    nMismatch++;
                    $display("[TB] FAIL clrall_strobe i=%0d: got cyc%0d kind%0d a%0d expected cyc%0d kind%0d a%0d", i,
                             obsLog[i].cyc, obsLog[i].kind, obsLog[i].addr, expLog[i].cyc, expLog[i].kind, expLog[i].addr);
                end
            end
        end
        nCompared++;
        if (obsBusy !== 9) begin nMismatch++; $display("[TB] FAIL clrall_busy: got %0d cycles expected 9", obsBusy); end
        for (int i = 1; i < DEPTH; i += 3) begin
            predict(0, 1, OP_READ, OP_READ, 3'd0, 3'(i), 32'd0, 32'd0);
            do_pair(0, 1, OP_READ, OP_READ, 3'd0, 3'(i), 32'd0, 32'd0);
            nCompared++;
            if (obsRdata[1] !== 32'h0) begin
                nMismatch++;
                $display("[TB] FAIL clrall_readback addr=%0d: got %h expected 0", i, obsRdata[1]);
            end
        end
    endtask

    task automatic test_rdata_hold();
        logic [31:0] v5, w3;
        v5 = $urandom | 32'h1;
        w3 = $urandom;
        predict(1, 0, OP_LOAD, OP_READ, 3'd5, 3'd0, v5, 32'd0);
        do_pair(1, 0, OP_LOAD, OP_READ, 3'd5, 3'd0, v5, 32'd0);
        predict(1, 0, OP_READ, OP_READ, 3'd5, 3'd0, 32'd0, 32'd0);
        do_pair(1, 0, OP_READ, OP_READ, 3'd5, 3'd0, 32'd0, 32'd0);
        nCompared++;
        if (obsRdata[0] !== v5) begin nMismatch++; $display("[TB] FAIL hold_read5: got %h expected %h", obsRdata[0], v5); end
        predict(0, 1, OP_READ, OP_LOAD, 3'd0, 3'd3, 32'd0, w3);
        do_pair(0, 1, OP_READ, OP_LOAD, 3'd0, 3'd3, 32'd0, w3);
        nCompared++;
        if (obsRdata[1] !== v5) begin nMismatch++; $display("[TB] FAIL hold_at_load_done: got %h expected %h", obsRdata[1], v5); end
        @(negedge clk);
        nCompared++;
        if (bus.rdata !== v5) begin nMismatch++; $display("[TB] FAIL hold_after_load: got %h expected %h", bus.rdata, v5); end
    endtask

    task automatic test_back_to_back();
        bit enA, enB;
        int en;
        logic [1:0] opA, opB;
        logic [2:0] adA, adB;
        logic [31:0] wdA, wdB;
        for (int it = 0; it < 30; it++) begin
            en  = $urandom_range(1, 3);
            enA = en[0]; enB = en[1];
            opA = 2'($urandom); opB = 2'($urandom);
            // keep clear-all rare so loads and reads dominate
            if (opA == OP_CLRALL && $urandom_range(0, 3) != 0) opA = OP_LOAD;
            if (opB == OP_CLRALL && $urandom_range(0, 3) != 0) opB = OP_READ;
            adA = 3'($urandom); adB = 3'($urandom);
            wdA = $urandom;     wdB = $urandom;
            predict(enA, enB, opA, opB, adA, adB, wdA, wdB);
            do_pair(enA, enB, opA, opB, adA, adB, wdA, wdB);
            nCompared++;
            if (obsTimeout !== 1'b0) begin nMismatch++; $display("[TB] FAIL b2b_timeout it=%0d: requests not all served", it); end
            nCompared++;
            if (obsOrder.size() !== expOrder.size()) begin
                nMismatch++;
                $display("[TB] FAIL b2b_grant_count it=%0d: got %0d expected %0d", it, obsOrder.size(), expOrder.size());
            end else begin
                for (int k = 0; k < expOrder.size(); k++) begin
                    nCompared++;
                    if (obsOrder[k] !== expOrder[k]) begin
                        nMismatch++;
                        $display("[TB] FAIL b2b_order it=%0d k=%0d: got port %0d expected port %0d", it, k, obsOrder[k], expOrder[k]);
                    end
                end
            end
            for (int p = 0; p < 2; p++) begin
                if ((p == 0 && enA) || (p == 1 && enB)) begin
                    nCompared++;
                    if (obsGntCyc[p] !== expGntCyc[p] || obsDoneCyc[p] !== expDoneCyc[p]
                        || obsGntCnt[p] !== 1 || obsDoneCnt[p] !== 1) begin
                        nMismatch++;
                        $display("[TB] FAIL b2b_timing it=%0d port=%0d: got gnt@%0d done@%0d (x%0d/x%0d) expected gnt@%0d done@%0d (x1/x1)",
                                 it, p, obsGntCyc[p], obsDoneCyc[p], obsGntCnt[p], obsDoneCnt[p], expGntCyc[p], expDoneCyc[p]);
                    end
                    nCompared++;
                    if (obsRdata[p] !== expRdataDone[p]) begin
                        nMismatch++;
                        $display("[TB] FAIL b2b_rdata it=%0d port=%0d: got %h expected %h", it, p, obsRdata[p], expRdataDone[p]);
                    end
                end
            end
            nCompared++;
            if (obsLog.size() !== expLog.size()) begin
                nMismatch++;
                $display("[TB] FAIL b2b_strobe_count it=%0d: got %0d expected %0d", it, obsLog.size(), expLog.size());
            end else begin
                for (int k = 0; k < expLog.size(); k++) begin
                    nCompared++;
                    if (obsLog[k] !== expLog[k]) begin
                        nMismatch++;
                        $display("[TB] FAIL b2b_strobe it=%0d k=%0d: got cyc%0d kind%0d a%0d d%h expected cyc%0d kind%0d a%0d d%h", it, k,
                                 obsLog[k].cyc, obsLog[k].kind, obsLog[k].addr, obsLog[k].din,
                                 expLog[k].cyc, expLog[k].kind, expLog[k].addr, expLog[k].din);
                    end
                end
            end
            nCompared++;
            if (obsIllegal !== 0 || obsBusy !== expBusy) begin
                nMismatch++;
                $display("[TB] FAIL b2b_busy_illegal it=%0d: got busy=%0d illegal=%0d expected busy=%0d illegal=0",
                         it, obsBusy, obsIllegal, expBusy);
            end
        end
    endtask

    task automatic test_reset_mid_sweep();
        int doneSeen;
        for (int i = 0; i < DEPTH; i++) begin
            predict(1, 0, OP_LOAD, OP_READ, 3'(i), 3'd0, 32'h1000 + 32'(i), 32'd0);
            do_pair(1, 0, OP_LOAD, OP_READ, 3'(i), 3'd0, 32'h1000 + 32'(i), 32'd0);
        end
        predict(0, 1, OP_READ, OP_READ, 3'd0, 3'd7, 32'd0, 32'd0);
        do_pair(0, 1, OP_READ, OP_READ, 3'd0, 3'd7, 32'd0, 32'd0);
        @(negedge clk);
        bus.req_a = 1'b1; bus.op_a = OP_CLRALL; bus.addr_a = 3'd6;
        @(negedge clk);
        nCompared++;
        if (bus.gnt_a !== 1'b1 || bus.sram_Clear !== 1'b1 || bus.sram_Address !== 3'd0) begin
            nMismatch++;
            $display("[TB] FAIL sweep_start: got gnt=%b clr=%b addr=%0d expected gnt=1 clr=1 addr=0",
                     bus.gnt_a, bus.sram_Clear, bus.sram_Address);
        end
        bus.req_a = 1'b0;
        repeat (3) @(negedge clk);
        nCompared++;
        if (bus.sram_Clear !== 1'b1 || bus.sram_Address !== 3'd3) begin
            nMismatch++;
            $display("[TB] FAIL sweep_cycle4: got clr=%b addr=%0d expected clr=1 addr=3", bus.sram_Clear, bus.sram_Address);
        end
        #1 rst = 1'b1;
        #1;
        nCompared++;
        if ({bus.sram_RD, bus.sram_Load, bus.sram_Clear, bus.busy} !== 4'b0 || bus.sram_Address !== 3'd0) begin
            nMismatch++;
            $display("[TB] FAIL midreset_strobes: got rd/ld/cl/busy=%b addr=%0d expected 0000 addr=0",
                     {bus.sram_RD, bus.sram_Load, bus.sram_Clear, bus.busy}, bus.sram_Address);
        end
        nCompared++;
        if (bus.rdata !== 32'h0) begin nMismatch++; $display("[TB] FAIL midreset_rdata: got %h expected 0", bus.rdata); end
        // addresses 0..2 were cleared before reset hit the cycle-4 clear
        for (int i = 0; i < 3; i++) expMem[i] = '0;
        expRdata = '0;
        lastGntB = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        doneSeen = 0;
        repeat (12) begin
            @(negedge clk);
            if (bus.done_a || bus.done_b || bus.busy) doneSeen++;
        end
        nCompared++;
        if (doneSeen !== 0) begin nMismatch++; $display("[TB] FAIL midreset_no_done: got %0d active cycles expected 0", doneSeen); end
        predict(1, 1, OP_READ, OP_READ, 3'd1, 3'd4, 32'd0, 32'd0);
        do_pair(1, 1, OP_READ, OP_READ, 3'd1, 3'd4, 32'd0, 32'd0);
        nCompared++;
        if (obsOrder.size() !== 2 || obsOrder[0] !== 0) begin
            nMismatch++;
            $display("[TB] FAIL midreset_prio: got %0d grants first=%0d expected 2 grants first=0", obsOrder.size(),
                     (obsOrder.size() > 0) ? obsOrder[0] : -1);
        end
        nCompared++;
        if (obsRdata[0] !== expRdataDone[0] || obsRdata[1] !== expRdataDone[1]) begin
            nMismatch++;
            $display("[TB] FAIL midreset_reads: got A=%h B=%h expected A=%h B=%h",
                     obsRdata[0], obsRdata[1], expRdataDone[0], expRdataDone[1]);
        end
        for (int i = 2; i < 4; i++) begin
            predict(0, 1, OP_READ, OP_READ, 3'd0, 3'(i), 32'd0, 32'd0);
            do_pair(0, 1, OP_READ, OP_READ, 3'd0, 3'(i), 32'd0, 32'd0);
            nCompared++;
            if (obsRdata[1] !== expRdataDone[1]) begin
                nMismatch++;
                $display("[TB] FAIL midreset_readback addr=%0d: got %h expected %h", i, obsRdata[1], expRdataDone[1]);
            end
        end
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst = 1'b1;
        bus.req_a = 1'b0; bus.op_a = 2'b00; bus.addr_a = '0; bus.wdata_a = '0;
        bus.req_b = 1'b0; bus.op_b = 2'b00; bus.addr_b = '0; bus.wdata_b = '0;
        for (int i = 0; i < DEPTH; i++) expMem[i] = '0;
        expRdata = '0;
        lastGntB = 1'b1;
        test_reset();
        test_load_fill();
        test_read_all();
        test_round_robin();
        test_clear_all();
        test_rdata_hold();
        test_back_to_back();
        test_reset_mid_sweep();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatch);
        $finish;
    end

endmodule

// File: doc/sram_arbiter.md
# sram_arbiter

Two-port arbiter and sequencer for the 8 x 32-bit `SRAM` latch bank in the calculator datapath. It accepts read, load, clear and clear-all requests from two masters (port A: calculator control unit; port B: display/debug scanner). It grants them round-robin and drives `SRAM`'s `RD`/`Load`/`Clear`/`Address`/`dataIn` strobes for exactly the required cycles. It returns read data with a one-cycle completion pulse.

## Interface
- `DATA_W`, 32, data width; matches `SRAM` `dataIn`/`dataOut`
- `ADDR_W`, 3, address width
- `DEPTH`, 8, locations swept by clear-all; equals 2^`ADDR_W`

Ports:
- `clk`  in  1  single clock; everything on the rising edge
- `rst`  in  1  asynchronous, active-high reset
- `req_a`, `req_b`  in  1  request from port A / B
- `op_a`, `op_b`  in  2  00 read, 01 load, 10 clear, 11 clear-all
- `addr_a`, `addr_b`  in  `ADDR_W`  target location (ignored for clear-all)
- `wdata_a`, `wdata_b`  in  `DATA_W`  load data
- `gnt_a`, `gnt_b`  out  1  one-cycle grant pulse
- `done_a`, `done_b`  out  1  one-cycle completion pulse
- `rdata`  out  `DATA_W`  last read result; shared by both ports
- `busy`  out  1  high in every state except IDLE
- `sram_RD`, `sram_Load`, `sram_Clear`  out  1  strobes to `SRAM`
- `sram_Address`  out  `ADDR_W`  address to `SRAM`
- `sram_dataIn`  out  `DATA_W`  write data to `SRAM`
- `sram_dataOut`  in  `DATA_W`  read data from `SRAM`

## Operation
- FSM states: IDLE, ISSUE, WAIT, SWEEP, DONE.
- IDLE:
  - Sample `req_a`/`req_b`.
  - If exactly one is high, grant it.
  - If both are high, grant the port named by the round-robin pointer `prio`. Reset value of `prio` is A.
  - After any grant, `prio` points to the other port.
  - On a grant, latch op, addr and wdata of the granted port, and pulse its `gnt_x`.
- ISSUE (read/load/clear): exactly one strobe is high for one cycle (`sram_RD`, `sram_Load` or `sram_Clear`), with `sram_Address` = latched addr. For load, `sram_dataIn` = latched wdata.
  - Read goes to WAIT.
  - Load and clear go to DONE.
- WAIT (read only): all strobes low. At the end of this cycle, `rdata` <= `sram_dataOut`. Next state is DONE.
- SWEEP (clear-all): `sram_Clear` is high for `DEPTH` consecutive cycles, with `sram_Address` = 0,1,...,`DEPTH`-1 from an internal counter. The address wraps to 0 and the FSM goes to DONE after address `DEPTH`-1.
- DONE: `done_x` is high for the granted port for one cycle. Next state is IDLE.
- At most one strobe is high in any cycle. All strobes are low in IDLE, WAIT and DONE.
- `sram_Address` and `sram_dataIn` return to 0 whenever no strobe is active.
- `rdata` holds its value until the next read completes. It is unchanged by load, clear and clear-all.
- Requester protocol: hold `req_x` and its op/addr/wdata until `gnt_x` is seen, then deassert `req_x`. A `req_x` still high in IDLE after `done_x` is treated as a new request.
- Requests arriving while `busy` wait. They are not dropped.
- Reset (async, any time, including mid-sweep): state IDLE, `prio` = A, sweep counter 0. All outputs are 0, including `rdata`, strobes, `gnt_*`, `done_*` and `busy`. The in-flight operation is abandoned with no `done` pulse.

## Timing
- All outputs are registered. There is no combinational path from inputs to outputs.
- Cycle numbering: cycle 0 is the cycle in which `req_x` is high and the FSM is in IDLE.
- Load/clear:
  - cycle 1: `gnt_x` and the strobe are high together.
  - cycle 2: `done_x` is high.
  - cycle 3: IDLE.
- Read:
  - cycle 1: `gnt_x` and `sram_RD`.
  - cycle 2: WAIT.
  - cycle 3: `done_x`, with `rdata` valid.
  - cycle 4: IDLE.
- Clear-all:
  - cycle 1: `gnt_x` plus the clear at address 0.
  - cycles 1..8: addresses 0..7.
  - cycle 9: `done_x`.
  - cycle 10: IDLE.
- Back-to-back operation: the earliest next grant comes one cycle after the IDLE cycle following DONE.
- `busy` is high from the grant cycle through the DONE cycle inclusive.

## Test plan
- Reset, then A loads 2*i to address i for i=0..7 -> each op gives a `sram_Load` pulse in the `gnt_a` cycle and `done_a` one cycle later. The SRAM model holds 0,2,...,14.
- B reads addresses 0..7 -> `done_b` 2 cycles after `gnt_b`, with `rdata` = 2*i each time. No `sram_Load`/`sram_Clear` activity.
- `req_a` and `req_b` raised in the same cycle, repeatedly -> grants alternate A,B,A,B starting with A after reset. Neither port is starved.
- A issues clear-all -> `sram_Clear` is high for 8 consecutive cycles with addresses 0..7, `done_a` follows in cycle 9, and subsequent reads return 0.
- `rst` asserted during sweep cycle 4 -> strobes, `busy` and `rdata` go to 0 immediately, with no `done`. After release, A wins a simultaneous A/B request.
- A read of location 5 followed by a load to location 3 -> `rdata` keeps the location-5 value through the load.
